shared_timer_arb: RTL and testbench

- Arbitrates one shared up-counter datapath between NREQ requesters; each requester asks for a timed interval of `dur` clock cycles.
- Grants round-robin, loads the winner's duration, runs the counter, and pulses a per-requester done.
- Sits between the timer clients and the counter, and is the only block that sequences the counter.

---
 rtl/shared_timer_pkg.sv | 13 +
 rtl/shared_timer_arb_rr_pick.sv | 55 +++++
 rtl/shared_timer_arb.sv | 103 ++++++++++
 tb/tb_shared_timer_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared timer arbiter: FSM state encoding and default sizes.
package shared_timer_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shared_timer_arb_rr_pick.sv
// Combinational winner selection for the shared timer: round-robin after i_ptr,
// or lowest-index-wins when SHARED_TIMER_FIXED_PRIO_EN is defined.
module rr_pick
    import shared_timer_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

`ifdef SHARED_TIMER_FIXED_PRIO_EN
    logic [PW-1:0] w_unused_ptr;
    assign w_unused_ptr = i_ptr;

    // Scan from the top down so the lowest set index is the last to overwrite.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = PW'(k);
                o_valid     = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] w_j;

    // Scan from farthest to nearest after i_ptr; the nearest set bit wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_j      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j]) begin
                o_onehot      = '0;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
                o_valid       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/shared_timer_arb.sv
// Shares one up-counter between NREQ timer clients: grant, count dur cycles, pulse done.
// SHARED_TIMER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module shared_timer_arb
    import shared_timer_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dur,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt_out
);

    localparam int PW = $clog2(NREQ);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [WIDTH-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_dur_lat;
    logic [PW-1:0]     w_ptr;
    logic [NREQ-1:0]   w_onehot;
    logic [PW-1:0]     w_idx;
    logic              w_valid;
    logic [WIDTH-1:0]  w_dur_win;

`ifdef SHARED_TIMER_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_ptr;
    assign w_ptr = r_ptr;

    // Pointer moves on every grant, so an aborted interval still rotates priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= PW'(NREQ - 1);
        else if (r_state == ST_IDLE && w_valid)
            r_ptr <= w_idx;
    end
`endif

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_onehot(w_onehot),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_dur_win = dur[int'(w_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_cnt     <= '0;
            r_dur_lat <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state   <= ST_COUNT;
                        r_gnt     <= w_onehot;
                        r_cnt     <= '0;
                        r_dur_lat <= (w_dur_win == '0) ? WIDTH'(1) : w_dur_win;
                    end
                end
                ST_COUNT: begin
                    // Abort takes precedence over the terminal count.
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt == r_dur_lat - WIDTH'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign busy    = (r_state != ST_IDLE);
    assign cnt_out = r_cnt;

endmodule

// File: tb/tb_shared_timer_arb.sv
// Directed self-checking bench for shared_timer_arb (NREQ=4, WIDTH=32).
// Honours SHARED_TIMER_FIXED_PRIO_EN when choosing expected grant order.
module tb_shared_timer_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dur;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    shared_timer_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dur    (dur),
        .abort  (abort),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_out(cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dur(input int i, input logic [WIDTH-1:0] v);
        dur[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, busy, 1'b0);
    endtask

    logic [NREQ-1:0] exp_rr [5];
    logic [NREQ-1:0] exp_after_abort;
    logic            seen_done;

    initial begin
        rst   = 1'b1;
        req   = '0;
        dur   = '0;
        abort = 1'b0;
`ifdef SHARED_TIMER_FIXED_PRIO_EN
        exp_rr          = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_after_abort = 4'b0001;
`else
        exp_rr          = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_after_abort = 4'b0100;
`endif
        tick();
        tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_done", done, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", cnt_out, 32'd0);
        rst = 1'b0;
        tick();

        // Single request, dur0=3
        set_dur(0, 32'd3);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("single_gnt_t1", gnt, 4'b0001);
        chk("single_cnt0", cnt_out, 32'd0);
        chk("single_busy", busy, 1'b1);
        chk("single_done_t1", done, 4'b0000);
        tick();
        chk("single_cnt1", cnt_out, 32'd1);
        tick();
        chk("single_cnt2", cnt_out, 32'd2);
        chk("single_done_t3", done, 4'b0000);
        tick();
        chk("single_done_t4", done, 4'b0001);
        chk("single_gnt_t4", gnt, 4'b0001);
        tick();
        chk("single_done_t5", done, 4'b0000);
        chk("single_gnt_t5", gnt, 4'b0000);
        chk("single_busy_t5", busy, 1'b0);
        chk("single_cnt_t5", cnt_out, 32'd0);

        // Zero duration behaves as 1
        set_dur(2, 32'd0);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("zero_gnt", gnt, 4'b0100);
        chk("zero_done_t1", done, 4'b0000);
        tick();
        chk("zero_done_t2", done, 4'b0100);
        tick();
        chk("zero_done_t3", done, 4'b0000);
        chk("zero_busy_t3", busy, 1'b0);

        // Abort mid-interval on requester 1
        set_dur(1, 32'd10);
        req = 4'b0010;
        tick();
        chk("abort_gnt", gnt, 4'b0010);
        req = 4'b0111;
        tick();
        tick();
        tick();
        tick();
        chk("abort_cnt4", cnt_out, 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_gnt", gnt, 4'b0000);
        chk("abort_idle_cnt", cnt_out, 32'd0);
        chk("abort_no_done", done, 4'b0000);
        tick();
        chk("abort_next_gnt", gnt, exp_after_abort);
        req = 4'b0000;
        wait_idle("abort_drain_timeout");

        // Abort coincident with terminal count
        set_dur(0, 32'd5);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("abtc_gnt", gnt, 4'b0001);
        tick();
        tick();
        tick();
        tick();
        chk("abtc_cnt4", cnt_out, 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abtc_busy", busy, 1'b0);
        chk("abtc_done", done, 4'b0000);
        tick();
        chk("abtc_done_after", done, 4'b0000);
        chk("abtc_busy_after", busy, 1'b0);

        // Asynchronous reset in the middle of COUNT
        set_dur(3, 32'd8);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        chk("rstmid_gnt", gnt, 4'b1000);
        for (int i = 0; i < 5; i++) tick();
        chk("rstmid_cnt5", cnt_out, 32'd5);
        rst = 1'b1;
        #1;
        chk("rstmid_gnt0", gnt, 4'b0000);
        chk("rstmid_done0", done, 4'b0000);
        chk("rstmid_busy0", busy, 1'b0);
        chk("rstmid_cnt0", cnt_out, 32'd0);
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done != 4'b0000) seen_done = 1'b1;
        end
        chk("rstmid_no_done", seen_done, 1'b0);

        // Round-robin with all requesters held, dur=2
        for (int i = 0; i < NREQ; i++) set_dur(i, 32'd2);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("rr_gnt%0d", g), gnt, exp_rr[g]);
            tick();
            chk($sformatf("rr_cnt%0d", g), cnt_out, 32'd1);
            tick();
            chk($sformatf("rr_done%0d", g), done, exp_rr[g]);
            tick();
            chk($sformatf("rr_idle%0d", g), gnt, 4'b0000);
        end
        req = 4'b0000;
        wait_idle("rr_drain_timeout");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
